// File: rtl/morse_decoder.sv
// Groups classified dot/dash symbols into letters by idle-gap timing and emits
// the ASCII code of each letter, plus one space per word gap.
module morse_decoder #(
   parameter int LETTER_GAP = 30000000,
   parameter int WORD_GAP   = 70000000,
   parameter int CNT_W      = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sym_valid,
   input  logic       sym_dash,
   input  logic       key_down,
   output logic       char_valid,
   output logic [7:0] char_code,
   output logic       char_err,
   output logic [2:0] sym_count,
   output logic       busy
);

   // sym_valid and char_valid are single-cycle strobes with no back-pressure:
   // sym_dash is meaningful only with sym_valid, char_code/char_err only with
   // char_valid (they hold their last value between strobes).
   typedef enum logic [1:0] {IDLE, COLLECT, WORDWAIT} state_t;

   localparam logic [CNT_W-1:0] LG_M1 = CNT_W'(LETTER_GAP - 1);
   localparam logic [CNT_W-1:0] WG_M1 = CNT_W'(WORD_GAP - 1);
   localparam logic [CNT_W-1:0] WG    = CNT_W'(WORD_GAP);

   state_t           state, state_nxt;
   logic [4:0]       pattern, pattern_nxt;
   logic [2:0]       cnt_nxt;
   logic [CNT_W-1:0] gap_cnt, gap_nxt;
   logic             ovf, ovf_nxt;
   logic             valid_nxt, err_nxt;
   logic [7:0]       code_nxt, lut_code;

   // Patterns are right-aligned: the first symbol is the MSB of the low len bits.
   function automatic logic [7:0] lookup(input logic [2:0] len, input logic [4:0] pat);
      logic [7:0] c;
      c = 8'h3F;
      case ({len, pat})
         {3'd1, 5'b00000}: c = 8'h45; {3'd1, 5'b00001}: c = 8'h54;
         {3'd2, 5'b00000}: c = 8'h49; {3'd2, 5'b00001}: c = 8'h41;
         {3'd2, 5'b00010}: c = 8'h4E; {3'd2, 5'b00011}: c = 8'h4D;
         {3'd3, 5'b00000}: c = 8'h53; {3'd3, 5'b00001}: c = 8'h55;
         {3'd3, 5'b00010}: c = 8'h52; {3'd3, 5'b00011}: c = 8'h57;
         {3'd3, 5'b00100}: c = 8'h44; {3'd3, 5'b00101}: c = 8'h4B;
         {3'd3, 5'b00110}: c = 8'h47; {3'd3, 5'b00111}: c = 8'h4F;
         {3'd4, 5'b00000}: c = 8'h48; {3'd4, 5'b00001}: c = 8'h56;
         {3'd4, 5'b00010}: c = 8'h46; {3'd4, 5'b00100}: c = 8'h4C;
         {3'd4, 5'b00110}: c = 8'h50; {3'd4, 5'b00111}: c = 8'h4A;
         {3'd4, 5'b01000}: c = 8'h42; {3'd4, 5'b01001}: c = 8'h58;
         {3'd4, 5'b01010}: c = 8'h43; {3'd4, 5'b01011}: c = 8'h59;
         {3'd4, 5'b01100}: c = 8'h5A; {3'd4, 5'b01101}: c = 8'h51;
         {3'd5, 5'b01111}: c = 8'h31; {3'd5, 5'b00111}: c = 8'h32;
         {3'd5, 5'b00011}: c = 8'h33; {3'd5, 5'b00001}: c = 8'h34;
         {3'd5, 5'b00000}: c = 8'h35; {3'd5, 5'b10000}: c = 8'h36;
         {3'd5, 5'b11000}: c = 8'h37; {3'd5, 5'b11100}: c = 8'h38;
         {3'd5, 5'b11110}: c = 8'h39; {3'd5, 5'b11111}: c = 8'h30;
         default:          c = 8'h3F;
      endcase
      return c;
   endfunction

   assign lut_code = ovf ? 8'h3F : lookup(sym_count, pattern);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pattern    <= '0;
         sym_count  <= '0;
         gap_cnt    <= '0;
         ovf        <= 1'b0;
         char_valid <= 1'b0;
         char_code  <= 8'h00;
         char_err   <= 1'b0;
      end else begin
         state      <= state_nxt;
         pattern    <= pattern_nxt;
         sym_count  <= cnt_nxt;
         gap_cnt    <= gap_nxt;
         ovf        <= ovf_nxt;
         char_valid <= valid_nxt;
         char_code  <= code_nxt;
         char_err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pattern_nxt = pattern;
      cnt_nxt     = sym_count;
      gap_nxt     = gap_cnt;
      ovf_nxt     = ovf;
      valid_nxt   = 1'b0;
      code_nxt    = char_code;
      err_nxt     = char_err;
      if (sym_valid) begin
         // A symbol always beats a coincident gap threshold.
         if (sym_count < 3'd5) begin
            pattern_nxt = {pattern[3:0], sym_dash};
            cnt_nxt     = sym_count + 3'd1;
         end else begin
            ovf_nxt = 1'b1;
         end
         gap_nxt   = '0;
         state_nxt = COLLECT;
      end else begin
         if (key_down || state == IDLE) gap_nxt = '0;
         else if (gap_cnt != WG)        gap_nxt = gap_cnt + CNT_W'(1);
         if (!key_down && state == COLLECT && gap_cnt == LG_M1) begin
            valid_nxt   = 1'b1;
            code_nxt    = lut_code;
            err_nxt     = ovf || (lut_code == 8'h3F);
            pattern_nxt = '0;
            cnt_nxt     = '0;
            ovf_nxt     = 1'b0;
            state_nxt   = WORDWAIT;
         end else if (!key_down && state == WORDWAIT && gap_cnt == WG_M1) begin
            valid_nxt = 1'b1;
            code_nxt  = 8'h20;
            err_nxt   = 1'b0;
            gap_nxt   = '0;
            state_nxt = IDLE;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: table of letters plus hand-written timing corners;
// every emission is checked for code, error flag and arrival cycle.
module tb_morse_decoder;

   localparam int LG = 10;
   localparam int WG = 25;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sym_valid = 1'b0;
   logic       sym_dash = 1'b0;
   logic       key_down = 1'b0;
   logic       char_valid;
   logic [7:0] char_code;
   logic       char_err;
   logic [2:0] sym_count;
   logic       busy;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_sym = 0;

   logic [8:0] exp_q[$];
   int         exp_cyc_q[$];

   typedef struct {
      int         len;
      logic [4:0] pat;
      logic [7:0] code;
      logic       err;
   } vec_t;

   vec_t vecs[13];

   morse_decoder #(.LETTER_GAP(LG), .WORD_GAP(WG), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_dash(sym_dash),
      .key_down(key_down), .char_valid(char_valid), .char_code(char_code),
      .char_err(char_err), .sym_count(sym_count), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_sym(input logic d);
      sym_valid = 1'b1;
      sym_dash  = d;
      last_sym  = cyc;
      step();
      sym_valid = 1'b0;
      sym_dash  = 1'b0;
   endtask

   task automatic expect_char(input logic [7:0] code, input logic err, input int at);
      exp_q.push_back({err, code});
      exp_cyc_q.push_back(at);
   endtask

   // Symbols 3 cycles apart, first symbol taken from the MSB of the len bits.
   task automatic send_letter(input int len, input logic [4:0] pat);
      for (int k = 0; k < len; k++) begin
         send_sym(pat[len-1-k]);
         if (k < len - 1) step(2);
      end
   endtask

   always @(negedge clk) begin
      logic [8:0] e;
      int         ec;
      if (char_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_char: got code=%0h err=%0b at cycle %0d, required no emission",
                     char_code, char_err, cyc);
         end else begin
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("char_code", {24'd0, char_code}, {24'd0, e[7:0]});
            check("char_err", {31'd0, char_err}, {31'd0, e[8]});
            check("char_cycle", cyc, ec);
         end
      end
   end

   initial begin
      vecs[0]  = '{2, 5'b00001, 8'h41, 1'b0};
      vecs[1]  = '{1, 5'b00000, 8'h45, 1'b0};
      vecs[2]  = '{1, 5'b00001, 8'h54, 1'b0};
      vecs[3]  = '{4, 5'b01000, 8'h42, 1'b0};
      vecs[4]  = '{5, 5'b11111, 8'h30, 1'b0};
      vecs[5]  = '{5, 5'b01111, 8'h31, 1'b0};
      vecs[6]  = '{5, 5'b00000, 8'h35, 1'b0};
      vecs[7]  = '{4, 5'b01101, 8'h51, 1'b0};
      vecs[8]  = '{3, 5'b00111, 8'h4F, 1'b0};
      vecs[9]  = '{2, 5'b00011, 8'h4D, 1'b0};
      vecs[10] = '{4, 5'b00101, 8'h3F, 1'b1};
      vecs[11] = '{4, 5'b01111, 8'h3F, 1'b1};
      vecs[12] = '{5, 5'b11110, 8'h39, 1'b0};

      // Reset state
      step(3);
      check("rst_char_valid", {31'd0, char_valid}, 0);
      check("rst_char_code", {24'd0, char_code}, 0);
      check("rst_char_err", {31'd0, char_err}, 0);
      check("rst_sym_count", {29'd0, sym_count}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      rst = 1'b0;
      step(5 + $urandom_range(0, 3));

      // Table of letters, each followed by a full word gap
      foreach (vecs[i]) begin
         send_letter(vecs[i].len, vecs[i].pat);
         check("collect_count", {29'd0, sym_count}, vecs[i].len);
         check("collect_busy", {31'd0, busy}, 1);
         expect_char(vecs[i].code, vecs[i].err, last_sym + LG + 1);
         expect_char(8'h20, 1'b0, last_sym + WG + 1);
         step(30);
         check("idle_busy", {31'd0, busy}, 0);
         check("hold_code", {24'd0, char_code}, 32'h20);
      end

      // Overflow: six dashes, then a clean letter
      for (int k = 0; k < 6; k++) begin
         send_sym(1'b1);
         if (k < 5) step(2);
      end
      check("ovf_count", {29'd0, sym_count}, 5);
      expect_char(8'h3F, 1'b1, last_sym + LG + 1);
      expect_char(8'h20, 1'b0, last_sym + WG + 1);
      step(30);
      send_letter(1, 5'b00001);
      expect_char(8'h54, 1'b0, last_sym + LG + 1);
      expect_char(8'h20, 1'b0, last_sym + WG + 1);
      step(30);

      // Key held down freezes the gap timer
      begin
         int rel;
         send_sym(1'b0);
         key_down = 1'b1;
         step(25);
         check("hold_count", {29'd0, sym_count}, 1);
         check("hold_busy", {31'd0, busy}, 1);
         step(25);
         key_down = 1'b0;
         rel = cyc;
         expect_char(8'h45, 1'b0, rel + LG);
         expect_char(8'h20, 1'b0, rel + WG);
         step(30);
      end

      // Symbol exactly on the letter threshold, then a symbol during word wait
      send_sym(1'b0);
      step(LG - 1);
      send_sym(1'b1);
      expect_char(8'h41, 1'b0, last_sym + LG + 1);
      step(16);
      send_sym(1'b1);
      check("ww_count", {29'd0, sym_count}, 1);
      check("ww_busy", {31'd0, busy}, 1);
      expect_char(8'h54, 1'b0, last_sym + LG + 1);
      expect_char(8'h20, 1'b0, last_sym + WG + 1);
      step(30);

      // Asynchronous reset mid-letter
      send_letter(3, 5'b00111);
      check("pre_rst_count", {29'd0, sym_count}, 3);
      rst = 1'b1;
      #2;
      check("async_count", {29'd0, sym_count}, 0);
      check("async_busy", {31'd0, busy}, 0);
      check("async_code", {24'd0, char_code}, 0);
      check("async_valid", {31'd0, char_valid}, 0);
      step(3);
      rst = 1'b0;
      step(40);
      send_letter(1, 5'b00000);
      expect_char(8'h45, 1'b0, last_sym + LG + 1);
      expect_char(8'h20, 1'b0, last_sym + WG + 1);
      step(30);

      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
Downstream stage of the push-button Morse keyer. It consumes classified dot/dash symbols, one per key release, and groups them into letters using idle-gap timing. It translates each letter into an ASCII code, plus a space at word gaps, for the display/UART stage that follows. It is fully synchronous to clk, with an asynchronous active-high reset.

Parameters:
LETTER_GAP, 30000000, idle clk cycles after the last symbol that close a letter (0.3 s at 100 MHz); must be >= 2
WORD_GAP, 70000000, idle clk cycles after the last symbol that emit a space; must be > LETTER_GAP
CNT_W, 32, width of the gap counter; must hold WORD_GAP

Ports:
clk  input  1  system clock (100 MHz board clock)
rst  input  1  asynchronous, active-high reset
sym_valid  input  1  one-cycle pulse: a new symbol is available
sym_dash  input  1  qualified by sym_valid: 1 = dash, 0 = dot
key_down  input  1  debounced key level; high = key pressed (gap timer held at 0)
char_valid  output  1  one-cycle pulse: char_code/char_err valid
char_code  output  8  ASCII of the decoded character
char_err  output  1  with char_valid: pattern unknown or too long
sym_count  output  3  symbols buffered in the current letter (0..5), for LEDs
busy  output  1  high when state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, pattern=0, sym_count=0, gap_cnt=0, ovf=0, char_valid=0, char_code=8'h00, char_err=0. No emission on reset exit. Any partial letter is discarded.
- States:
  - IDLE: no letter pending.
  - COLLECT: symbols buffered.
  - WORDWAIT: letter emitted, word-gap timing in progress.
- Symbol capture (any state, sym_valid=1):
  - If sym_count<5: pattern <= {pattern[3:0], sym_dash} (first symbol ends up most significant of the sym_count LSBs); sym_count+1.
  - If sym_count==5: ovf<=1; pattern and sym_count unchanged.
  - gap_cnt<=0; state<=COLLECT.
- Gap counter: cleared on sym_valid or key_down=1. Otherwise it increments by 1 per cycle in COLLECT/WORDWAIT, saturates at WORD_GAP, and holds 0 in IDLE.
- Letter close: in COLLECT with no sym_valid, key_down=0 and gap_cnt==LETTER_GAP-1, the next edge does all of the following:
  - char_valid=1 for exactly one cycle; char_code=lookup(sym_count, pattern); char_err=ovf|unknown.
  - pattern=0, sym_count=0, ovf=0; gap_cnt keeps counting; state=WORDWAIT.
- Letter latency: char_valid is high in the cycle following the LETTER_GAP-th consecutive idle cycle after the last sym_valid.
- Word close: in WORDWAIT with key_down=0 and gap_cnt==WORD_GAP-1, the next edge gives char_valid=1, char_code=8'h20, char_err=0, state=IDLE.
- Spaces: exactly one space per gap, never before the first letter after reset/IDLE.
- Lookup:
  - Full International Morse A-Z (uppercase ASCII 8'h41-8'h5A) and 0-9 (8'h30-8'h39), keyed on (length, pattern). Examples: len1 0=E, len1 1=T, len2 01=A, len4 1000=B, len5 11111=0, len5 01111=1.
  - Unmapped pattern or ovf: char_code=8'h3F ('?'), char_err=1.
- char_code/char_err hold their last value between pulses; char_valid is a registered, one-cycle output.
- Simultaneous events:
  - sym_valid in the same cycle as a letter/word threshold: the symbol wins, no emission, gap_cnt=0.
  - key_down=1 at the threshold: the counter clears, no emission.
- sym_valid while key_down=1 is accepted normally.
- sym_count output = internal count; busy = (state!=IDLE).

Test Plan (LETTER_GAP=10, WORD_GAP=25, CNT_W=8):
- Dot, dash pulses 3 cycles apart, then idle -> char_valid once, 10 cycles after the 2nd pulse +1, char_code=8'h41 'A', char_err=0; 15 cycles later char_code=8'h20; busy drops.
- Five dashes, then idle -> 8'h30 '0'; a sixth dash -> 8'h3F with char_err=1, and the next letter decodes cleanly (ovf cleared).
- Pattern dot-dash-dot-dash (unmapped) -> 8'h3F, char_err=1.
- Dot, then key_down held high for 50 cycles, release, idle -> no emission during hold; 'E' (8'h45) after 10 idle cycles post-release.
- sym_valid asserted exactly on the 10th idle cycle -> no emission; a 2-symbol letter decodes later; then a new symbol during WORDWAIT -> no space emitted, a new letter collects.
- rst pulsed mid-letter (sym_count=3) -> outputs 0 immediately (async), no char_valid afterwards, and the next letter decodes from an empty pattern.
